spi_slave_responder: RTL and testbench
======================================

Name: spi_slave_responder

Overview:
SPI slave (responder) end of the team's SPI link, the counterpart to the master that drives SCLK/SS_n/MOSI. It runs entirely in the system clk domain: it synchronises the external SPI pins, detects SCLK edges, and supports all four CPOL/CPHA modes. It shifts received MOSI bytes into rx_data with a one-cycle valid pulse, and serves MISO from a single-entry transmit buffer filled by local logic. Multi-byte frames (SS_n held low) and mid-byte aborts are supported.

Parameters:
WIDTH, 8, bits per SPI word; MSB first.
SYNC_STAGES, 2, flop depth of the sclk/ss_n/mosi synchronisers (>=2).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
CPOL  input  1  SCLK idle level; latched at frame start.
CPHA  input  1  0: sample on leading edge; 1: sample on trailing edge. Latched at frame start.
sclk  input  1  SPI clock from master (asynchronous).
ss_n  input  1  slave select, active-low (asynchronous).
mosi  input  1  master-out data (asynchronous).
miso  output  1  slave-out data.
miso_oe  output  1  high while a frame is active; tri-state enable for the pad.
tx_data  input  WIDTH  next word to transmit.
tx_load  input  1  write tx_data into the buffer; accepted only when tx_ready=1.
tx_ready  output  1  transmit buffer empty.
rx_data  output  WIDTH  last completed received word; held until the next completion.
rx_valid  output  1  one-clk pulse when rx_data updates.
tx_underrun  output  1  one-clk pulse when a word is consumed from an empty buffer.
abort  output  1  one-clk pulse when SS_n rises mid-word.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, abort=0, state=WAIT. ss_n synchroniser flops reset to 0; sclk/mosi synchroniser flops reset to 0.
- Synchronised signals: sclk_s, ss_n_s and mosi_s are the last stage of their synchronisers. sclk_prev is registered from sclk_s.
- Edge definitions, using the latched CPOL:
  - leading edge: sclk_prev==CPOL_l and sclk_s!=CPOL_l.
  - trailing edge: the opposite transition.
  - sample edge = leading if CPHA_l=0, else trailing; shift edge is the other one.
- Timing constraint: SCLK high and low times are each >= SYNC_STAGES+1 clk cycles. MISO changes SYNC_STAGES+1 clk after the SCLK shift edge.
- State WAIT: stay until ss_n_s==1, then go to IDLE. This prevents a false frame start when reset is released while SS_n is low.
- State IDLE, on ss_n_s==0 (frame start):
  - Latch CPOL_l/CPHA_l; load sclk_prev=sclk_s.
  - Consume the buffer into tx_shift: if empty, load 0 and pulse tx_underrun.
  - Set bit_cnt=0, tx_cnt=0, first_shift=1; go to ACTIVE.
- ACTIVE outputs: miso = tx_shift[WIDTH-1]; miso_oe=1.
- Sample edge:
  - rx_shift <= {rx_shift[WIDTH-2:0], mosi_s}; bit_cnt++.
  - When bit_cnt reaches WIDTH: rx_data <= completed word, rx_valid pulse, bit_cnt=0.
- Shift edge:
  - If CPHA_l=1 and first_shift=1: clear first_shift only. The MSB was already presented at frame start.
  - Else if tx_cnt==WIDTH-1: reload tx_shift from the buffer (underrun rule as above); tx_cnt=0.
  - Else shift tx_shift left by one; tx_cnt++.
  - For CPHA_l=0, clear first_shift on the first shift edge as well.
- ss_n_s==1 while ACTIVE:
  - If bit_cnt!=0: pulse abort; discard the partial word; no rx_valid.
  - If bit_cnt==0: clean end, no pulse.
  - In both cases go to IDLE, miso_oe=0, miso=0. The unused buffer content is retained.
- Transmit buffer:
  - tx_ready = buffer empty.
  - tx_load with tx_ready=1 fills the buffer; tx_load with tx_ready=0 is ignored.
  - Consume and load in the same cycle: the consume sees the old (empty) state and pulses underrun; the buffer ends full with the new word.
- Reset mid-frame: all state clears immediately and the block goes to WAIT. The remaining bits of the frame are ignored until SS_n is deasserted.

Test Plan:
- Mode 0, buffer=0xA5, master sends 0x3C over 8 SCLK periods (8 clk half-period) -> miso bit stream 1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid pulse; tx_ready=1 after frame start.
- Repeat with 0xA5 and 0x3C for modes 1, 2 and 3 -> identical data results in every mode. For CPHA=1, miso holds MSB=1 until the first leading edge is passed.
- Back-to-back frame: SS_n held low for 16 bits, master sends 0x12,0x34; buffer loaded 0xF0 then 0x0F (the second load happens after the first consume) -> rx_valid twice (0x12, then 0x34); miso stream 0xF0 then 0x0F; no underrun.
- Empty buffer at frame start -> tx_underrun pulse; miso all zeros for 8 bits; rx still correct (master sends 0x81 -> rx_data=0x81).
- SS_n rises after 3 bits of 0xC3 -> abort pulse; rx_data keeps the previous value; no rx_valid; next full frame of 0x55 is received correctly.
- Reset asserted after 4 bits with SS_n low, released with SS_n still low, remaining bits clocked -> no rx_valid; after an SS_n high/low cycle, a new frame of 0x99 gives rx_data=0x99.

Source files
------------

// File: rtl/spi_slave_responder.sv
// SPI slave running in the system clock domain: synchronises the SPI pins, supports all four
// CPOL/CPHA modes, and serves MISO from a single-entry transmit buffer.
module spi_slave_responder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CPOL,
  input  logic             CPHA,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             abort
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {WAIT, IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_n_sync, mosi_sync;
  logic                   sclk_s, ss_n_s, mosi_s;
  logic                   sclk_prev;
  logic                   cpol_l, cpha_l;
  logic                   first_shift;
  logic [CNT_W-1:0]       bit_cnt, tx_cnt;
  logic [WIDTH-1:0]       tx_shift;
  logic [WIDTH-2:0]       rx_shift;
  logic [WIDTH-1:0]       rx_word;
  logic [WIDTH-1:0]       buf_data;
  logic                   buf_full;

  logic frame_start, frame_end;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic skip_shift, reload, consume, load_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      ss_n_sync <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_n_s = ss_n_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT;
    else        state <= state_next;
  end

  // WAIT holds off frame detection until SS_n has been seen high at least once.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    miso        = 1'b0;
    miso_oe     = 1'b0;
    case (state)
      WAIT: if (ss_n_s) state_next = IDLE;
      IDLE: begin
        if (!ss_n_s) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        miso    = tx_shift[WIDTH-1];
        miso_oe = 1'b1;
        if (ss_n_s) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end
      end
      default: state_next = WAIT;
    endcase
  end

  always_comb begin
    lead_edge   = (state == ACTIVE) && !ss_n_s && (sclk_prev == cpol_l) && (sclk_s != cpol_l);
    trail_edge  = (state == ACTIVE) && !ss_n_s && (sclk_prev != cpol_l) && (sclk_s == cpol_l);
    sample_edge = cpha_l ? trail_edge : lead_edge;
    shift_edge  = cpha_l ? lead_edge : trail_edge;
    skip_shift  = cpha_l && first_shift;
    reload      = shift_edge && !skip_shift && (tx_cnt == CNT_W'(WIDTH - 1));
    consume     = frame_start || reload;
    load_ok     = tx_load && !buf_full;
    rx_word     = {rx_shift, mosi_s};
  end

  assign tx_ready = !buf_full;

  // A consume and a load in the same cycle leave the buffer full with the new word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_prev   <= 1'b0;
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      first_shift <= 1'b0;
      bit_cnt     <= '0;
      tx_cnt      <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      abort       <= 1'b0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
    end else begin
      sclk_prev   <= sclk_s;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      abort       <= 1'b0;

      if (consume) begin
        buf_full <= 1'b0;
        if (!buf_full) tx_underrun <= 1'b1;
      end
      if (load_ok) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end

      if (frame_start) begin
        cpol_l      <= CPOL;
        cpha_l      <= CPHA;
        tx_shift    <= buf_full ? buf_data : '0;
        bit_cnt     <= '0;
        tx_cnt      <= '0;
        first_shift <= 1'b1;
      end

      if (frame_end) begin
        if (bit_cnt != '0) abort <= 1'b1;
        bit_cnt <= '0;
      end

      if (sample_edge) begin
        rx_shift <= rx_word[WIDTH-2:0];
        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      // With CPHA=1 the first shift edge only arms shifting; the MSB is already on MISO.
      if (shift_edge) begin
        first_shift <= 1'b0;
        if (!skip_shift) begin
          if (tx_cnt == CNT_W'(WIDTH - 1)) begin
            tx_shift <= buf_full ? buf_data : '0;
            tx_cnt   <= '0;
          end else begin
            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            tx_cnt   <= tx_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Testbench for spi_slave_responder: an SPI master drives directed and random frames and
// compares MISO, received words and status pulses with a word-level reference model.
module tb_spi_slave_responder;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset, CPOL, CPHA, sclk, ss_n, mosi, tx_load;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, abort;
  logic [7:0] rx_data;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] rx_q[$];
  int         unr_cnt = 0;
  int         abort_cnt = 0;

  bit         model_full = 1'b0;
  logic [7:0] model_word = 8'h00;
  logic [7:0] last_rx = 8'h00;
  int         exp_unr = 0;

  spi_slave_responder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .CPOL(CPOL), .CPHA(CPHA), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .abort(abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (tx_underrun) unr_cnt++;
      if (abort) abort_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    check("tx_ready_before_load", tx_ready, !model_full);
    tx_data = w;
    tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
    if (!model_full) begin
      model_full = 1'b1;
      model_word = w;
    end
  endtask

  // Model of a buffer consume: the stored word, or zero plus an expected underrun.
  function automatic logic [7:0] consume();
    if (model_full) begin
      model_full = 1'b0;
      return model_word;
    end
    exp_unr++;
    return 8'h00;
  endfunction

  task automatic do_bit(input bit cpol, input bit cpha, input bit mo, output bit seen);
    if (!cpha) begin
      mosi = mo;
      wait_clks(H);
      seen = miso;
      sclk = ~cpol;
      wait_clks(H);
      sclk = cpol;
    end else begin
      sclk = ~cpol;
      mosi = mo;
      wait_clks(H);
      seen = miso;
      sclk = cpol;
      wait_clks(H);
    end
  endtask

  // Master sends the first nbits of mdata (MSB first); a refill word may be loaded after start.
  task automatic run_frame(input bit cpol, input bit cpha, input logic [15:0] mdata,
                           input int nbits, input bit refill, input logic [7:0] rword);
    logic [7:0] words [3];
    logic [7:0] got;
    int         reloads, rx_before, unr_before, ab_before, nfull;
    bit         seen;
    CPOL = cpol;
    CPHA = cpha;
    sclk = cpol;
    mosi = 1'b0;
    wait_clks(4);
    rx_before  = rx_q.size();
    unr_before = unr_cnt;
    ab_before  = abort_cnt;
    exp_unr    = 0;
    words[0]   = consume();
    words[1]   = 8'h00;
    words[2]   = 8'h00;
    ss_n = 1'b0;
    wait_clks(H);
    check("frame_miso_oe", miso_oe, 1);
    check("frame_first_msb", miso, words[0][7]);
    check("tx_ready_after_start", tx_ready, !model_full);
    if (refill) load_word(rword);
    reloads = cpha ? (nbits - 1) / 8 : nbits / 8;
    for (int r = 1; r <= reloads; r++) words[r] = consume();
    for (int i = 0; i < nbits; i++) begin
      do_bit(cpol, cpha, mdata[15-i], seen);
      check("miso_bit", seen, words[i/8][7-(i%8)]);
    end
    wait_clks(H);
    ss_n = 1'b1;
    wait_clks(2 * H);
    check("end_miso_oe", miso_oe, 0);
    check("end_miso", miso, 0);
    nfull = nbits / 8;
    check("rx_count", rx_q.size() - rx_before, nfull);
    for (int k = 0; k < nfull; k++) begin
      got = (rx_before + k < rx_q.size()) ? rx_q[rx_before+k] : 8'hxx;
      check("rx_word", got, mdata[15-8*k -: 8]);
      last_rx = mdata[15-8*k -: 8];
    end
    check("rx_data_hold", rx_data, last_rx);
    check("underrun_count", unr_cnt - unr_before, exp_unr);
    check("abort_count", abort_cnt - ab_before, (nbits % 8) != 0);
  endtask

  initial begin
    int         rx_before;
    bit         seen;
    bit         rcpol, rcpha, rpre, rref;
    int         rbits;
    logic [15:0] rdata;
    reset = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    wait_clks(5);
    check("reset_miso", miso, 0);
    check("reset_miso_oe", miso_oe, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_underrun", tx_underrun, 0);
    check("reset_abort", abort, 0);
    reset = 1'b1;
    wait_clks(6);

    // Same data in all four modes.
    for (int m = 0; m < 4; m++) begin
      load_word(8'hA5);
      run_frame(m[1], m[0], 16'h3C00, 8, 1'b0, 8'h00);
    end

    // Two-word frame with a refill after the first consume.
    load_word(8'hF0);
    run_frame(1'b0, 1'b1, 16'h1234, 16, 1'b1, 8'h0F);

    // Empty buffer at frame start.
    run_frame(1'b0, 1'b1, 16'h8100, 8, 1'b0, 8'h00);

    // Abort after three bits, then a clean frame.
    load_word(8'h3C);
    run_frame(1'b1, 1'b1, 16'hC300, 3, 1'b0, 8'h00);
    load_word(8'h6B);
    run_frame(1'b1, 1'b1, 16'h5500, 8, 1'b0, 8'h00);

    // Reset in the middle of a frame with SS_n held low.
    load_word(8'h5A);
    CPOL = 1'b0; CPHA = 1'b0; sclk = 1'b0;
    wait_clks(4);
    void'(consume());
    ss_n = 1'b0;
    wait_clks(H);
    for (int i = 0; i < 4; i++) do_bit(1'b0, 1'b0, i[0], seen);
    reset = 1'b0;
    wait_clks(3);
    model_full = 1'b0;
    last_rx    = 8'h00;
    check("midreset_rx_data", rx_data, 0);
    check("midreset_tx_ready", tx_ready, 1);
    check("midreset_miso_oe", miso_oe, 0);
    reset = 1'b1;
    wait_clks(4);
    rx_before = rx_q.size();
    for (int i = 0; i < 4; i++) do_bit(1'b0, 1'b0, ~i[0], seen);
    wait_clks(H);
    check("wait_miso_oe", miso_oe, 0);
    check("wait_no_rx", rx_q.size() - rx_before, 0);
    ss_n = 1'b1;
    wait_clks(2 * H);
    load_word(8'h66);
    run_frame(1'b0, 1'b0, 16'h9900, 8, 1'b0, 8'h00);

    // Random modes, lengths, buffer use and data.
    for (int n = 0; n < 10; n++) begin
      rcpol = 1'($urandom);
      rcpha = 1'($urandom);
      rpre  = 1'($urandom);
      rref  = 1'($urandom);
      rbits = $urandom_range(1, 16);
      rdata = 16'($urandom);
      if (rpre) load_word(8'($urandom));
      run_frame(rcpol, rcpha, rdata, rbits, rref, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
